axis_s2c_skid_slice: RTL

Registered AXI4-Stream slice for the system-to-card (s2c) direction, the counterpart of the c2s output register stage. It accepts 256-bit beats from the host-side DMA stream and presents them to the decompression core. It runs a full valid/ready handshake with a 2-entry skid buffer, so the upstream tready is registered and throughput stays at 1 beat/cycle. It also keeps packet and byte statistics and a sticky tkeep protocol-error flag.

---
 rtl/axis_s2c_skid_slice.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/axis_s2c_skid_slice.sv
// Registered AXI4-Stream s2c slice with 2-entry skid buffer,
// packet/byte statistics and a sticky tkeep protocol-error flag.
//
// Ports:
//   aclk, aresetn         clock, async active-low reset
//   axis_*_s2c            upstream beat (tdata/tkeep/tlast/tvalid), tready out
//   axis_t* / tready      downstream beat out, downstream ready in
//   stats_clear           synchronous clear of counters and err_keep
//   pkt_count, byte_count delivered packets / bytes (wrap)
//   err_keep              sticky tkeep protocol error
module axis_s2c_skid_slice #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] axis_tdata_s2c,
    input  logic [KEEP_W-1:0] axis_tkeep_s2c,
    input  logic              axis_tlast_s2c,
    input  logic              axis_tvalid_s2c,
    output logic              axis_tready_s2c,
    output logic [DATA_W-1:0] axis_tdata,
    output logic [KEEP_W-1:0] axis_tkeep,
    output logic              axis_tlast,
    output logic              axis_tvalid,
    input  logic              tready,
    input  logic              stats_clear,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  byte_count,
    output logic              err_keep
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_n;

    logic              ready_q;
    logic [DATA_W-1:0] out_data, skid_data;
    logic [KEEP_W-1:0] out_keep, skid_keep;
    logic              out_last, skid_last;

    logic acc, dlv;
    logic load_out, load_skid, out_from_skid;

    assign acc = axis_tvalid_s2c && ready_q;
    assign dlv = (state != EMPTY) && tready;

    always_comb begin
        state_n       = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_n  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (acc && dlv) begin
                    load_out = 1'b1;
                end else if (acc) begin
                    state_n   = FULL;
                    load_skid = 1'b1;
                end else if (dlv) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (dlv) begin
                    state_n       = ONE;
                    out_from_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Ready is the registered "skid will be empty" condition, so the
    // upstream never sees a combinational path from downstream tready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n != FULL);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            skid_data <= '0;
            skid_keep <= '0;
            skid_last <= 1'b0;
        end else begin
            if (load_out) begin
                out_data <= axis_tdata_s2c;
                out_keep <= axis_tkeep_s2c;
                out_last <= axis_tlast_s2c;
            end else if (out_from_skid) begin
                out_data <= skid_data;
                out_keep <= skid_keep;
                out_last <= skid_last;
            end
            if (load_skid) begin
                skid_data <= axis_tdata_s2c;
                skid_keep <= axis_tkeep_s2c;
                skid_last <= axis_tlast_s2c;
            end
        end
    end

    // Last-beat keep must be a nonzero run of ones from bit 0:
    // adding 1 to such a mask clears every set bit.
    logic keep_ones, keep_contig, keep_bad;

    assign keep_ones   = &axis_tkeep_s2c;
    assign keep_contig = (|axis_tkeep_s2c) &&
        ((axis_tkeep_s2c & (axis_tkeep_s2c + KEEP_W'(1))) == '0);
    assign keep_bad    = acc &&
        (axis_tlast_s2c ? !keep_contig : !keep_ones);

    logic [CNT_W-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            pop = pop + CNT_W'(out_keep[i]);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count  <= '0;
            byte_count <= '0;
            err_keep   <= 1'b0;
        end else if (stats_clear) begin
            pkt_count  <= '0;
            byte_count <= '0;
            err_keep   <= 1'b0;
        end else begin
            if (dlv) begin
                byte_count <= byte_count + pop;
            end
            if (dlv && out_last) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
            if (keep_bad) begin
                err_keep <= 1'b1;
            end
        end
    end

    assign axis_tready_s2c = ready_q;
    assign axis_tvalid     = (state != EMPTY);
    assign axis_tdata      = out_data;
    assign axis_tkeep      = out_keep;
    assign axis_tlast      = out_last;

endmodule
